test_harness_ctrl: RTL and testbench

TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

---
 rtl/test_harness_pkg.sv | 23 ++
 rtl/test_harness_ctrl_trap_detector.sv | 52 +++++
 rtl/test_harness_ctrl.sv | 126 ++++++++++++
 tb/tb_test_harness_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/test_harness_pkg.sv
// Shared types and default constants for the CPU test harness controller.
package test_harness_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_RESET_CYCLES   = 50000;
  localparam int DEF_TRAP_REPEAT    = 3;
  localparam int DEF_PASS_ADDR      = 16'h3469;
  localparam int DEF_TIMEOUT_CYCLES = 100000000;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/test_harness_ctrl_trap_detector.sv
// Trap detector: tracks the last opcode-fetch address and how many times in a
// row it has been fetched. o_trap pulses (combinationally, one cycle) on the
// fetch that makes the run length reach TRAP_REPEAT; trap_addr is latched on
// the same edge. i_force_load latches the current address without a trap
// (used for the timeout path).
module trap_detector
  import test_harness_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TRAP_REPEAT = DEF_TRAP_REPEAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_sync,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_force_load,
  output logic              o_trap,
  output logic [ADDR_W-1:0] o_trap_addr
);

  localparam int REP_W = cnt_bits(TRAP_REPEAT);

  logic [REP_W-1:0]  r_rep_cnt;
  logic [REP_W-1:0]  w_rep_next;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_trap_addr;
  logic              w_fetch;

  assign w_fetch     = i_en && i_sync;
  assign w_rep_next  = (i_addr == r_last_addr) ? (r_rep_cnt + REP_W'(1)) : REP_W'(1);
  assign o_trap      = w_fetch && (w_rep_next >= REP_W'(TRAP_REPEAT));
  assign o_trap_addr = r_trap_addr;

  // Run-length tracking of fetch addresses and trap address capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rep_cnt   <= '0;
      r_last_addr <= '0;
      r_trap_addr <= '0;
    end else begin
      if (w_fetch) begin
        r_last_addr <= i_addr;
        r_rep_cnt   <= w_rep_next;
      end
      if (o_trap || i_force_load) begin
        r_trap_addr <= i_addr;
      end
    end
  end

endmodule

// File: rtl/test_harness_ctrl.sv
// Test harness controller: holds the CPU in reset, then lets it run while
// counting cycles, and declares pass/fail when the CPU spins on one opcode
// address. Optional run timeout enabled by defining TEST_HARNESS_TIMEOUT_EN.
module test_harness_ctrl
  import test_harness_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TRAP_REPEAT    = DEF_TRAP_REPEAT,
  parameter int PASS_ADDR      = DEF_PASS_ADDR,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              sync,
  output logic              cpu_reset,
  output logic              rdy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] trap_addr,
  output logic [CNT_W-1:0]  cycles
);

  localparam int HOLD_W = cnt_bits(RESET_CYCLES);

  state_t            r_state;
  state_t            w_state_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]  r_cycles;
  logic [CNT_W-1:0]  w_cycles_inc;
  logic              w_run;
  logic              w_trap;
  logic              w_trap_is_pass;
  logic              w_force_load;

  assign w_run          = (r_state == ST_RUN);
  assign w_cycles_inc   = (&r_cycles) ? r_cycles : (r_cycles + CNT_W'(1));
  assign w_trap_is_pass = (addr == ADDR_W'(PASS_ADDR));
  assign cycles         = r_cycles;

`ifdef TEST_HARNESS_TIMEOUT_EN
  // Compare in a domain wide enough that a limit beyond the counter range never fires.
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;
  logic w_timeout;
  assign w_timeout    = w_run && !w_trap &&
                        (CMP_W'(w_cycles_inc) == CMP_W'(TIMEOUT_CYCLES));
  assign w_force_load = w_timeout;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_force_load = 1'b0;
`endif

  trap_detector #(
    .ADDR_W      (ADDR_W),
    .TRAP_REPEAT (TRAP_REPEAT)
  ) u_trap_detector (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_run),
    .i_sync       (sync),
    .i_addr       (addr),
    .i_force_load (w_force_load),
    .o_trap       (w_trap),
    .o_trap_addr  (trap_addr)
  );

  // State register, reset-hold countdown and saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= HOLD_W'(RESET_CYCLES);
      r_cycles   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end
      if (w_run) begin
        r_cycles <= w_cycles_inc;
      end
    end
  end

  // Next-state decode and state-driven outputs; RUN is entered on the edge
  // the hold counter reaches zero.
  always_comb begin
    w_state_next = r_state;
    cpu_reset    = 1'b0;
    rdy          = 1'b0;
    done         = 1'b0;
    pass         = 1'b0;
    case (r_state)
      ST_HOLD: begin
        cpu_reset = 1'b1;
        rdy       = 1'b1;
        if (r_hold_cnt <= HOLD_W'(1)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        rdy = 1'b1;
        if (w_trap) begin
          w_state_next = w_trap_is_pass ? ST_PASS : ST_FAIL;
        end
`ifdef TEST_HARNESS_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_next = ST_FAIL;
        end
`endif
      end
      ST_PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      ST_FAIL: begin
        done = 1'b1;
      end
      default: begin
        w_state_next = ST_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Bench for test_harness_ctrl: table of trap sequences with a scoreboard,
// plus hand-written hold, reset-mid-run, timeout and saturation sequences.
module tb_test_harness_ctrl;

  localparam int RST = 10;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset2 = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        sync = 1'b0;
  logic        sync2 = 1'b0;

  logic        cpu_reset, rdy, done, pass;
  logic [15:0] trap_addr;
  logic [31:0] cycles;
  logic        cpu_reset2, rdy2, done2, pass2;
  logic [15:0] trap_addr2;
  logic [3:0]  cycles2;

  always #5 clk = ~clk;

  test_harness_ctrl #(
    .ADDR_W(16), .CNT_W(32), .RESET_CYCLES(RST), .TRAP_REPEAT(3),
    .PASS_ADDR(16'h3469), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .sync(sync),
    .cpu_reset(cpu_reset), .rdy(rdy), .done(done), .pass(pass),
    .trap_addr(trap_addr), .cycles(cycles)
  );

  test_harness_ctrl #(
    .ADDR_W(16), .CNT_W(4), .RESET_CYCLES(2), .TRAP_REPEAT(1),
    .PASS_ADDR(16'h3469), .TIMEOUT_CYCLES(1000)
  ) dut_sat (
    .clk(clk), .reset(reset2), .addr(addr), .sync(sync2),
    .cpu_reset(cpu_reset2), .rdy(rdy2), .done(done2), .pass(pass2),
    .trap_addr(trap_addr2), .cycles(cycles2)
  );

  typedef struct {
    int          n;
    logic [15:0] seq [6];
    int          trap_idx;
    logic        exp_pass;
    logic [15:0] exp_taddr;
  } vec_t;

  typedef struct {
    logic        pass;
    logic [15:0] taddr;
    int unsigned cyc;
  } exp_t;

  vec_t        vt [5];
  exp_t        sb_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_cycles = 0;
  bit          m_run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // One clock; the model counts run cycles on the edge, outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (m_run) begin
      if (exp_cycles != 32'hFFFF_FFFF) exp_cycles++;
`ifdef TEST_HARNESS_TIMEOUT_EN
      if (exp_cycles == TMO) m_run = 1'b0;
`endif
    end
    @(negedge clk);
  endtask

  // Reset just released: cpu_reset stays high for RST samples, then run starts at 0.
  // Sync is held active at the pass address to show HOLD ignores fetches.
  task automatic hold_check();
    addr = 16'h3469;
    sync = 1'b1;
    for (int k = 0; k <= RST; k++) begin
      chk($sformatf("hold_cpu_reset_%0d", k), {31'd0, cpu_reset}, {31'd0, (k < RST)});
      if (k < RST) tick();
    end
    chk("hold_end_cycles", cycles, 32'd0);
    chk("hold_end_done", {31'd0, done}, 32'd0);
    sync = 1'b0;
    addr = 16'hFFFF;
    m_run = 1'b1;
    exp_cycles = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sync = 1'b0;
    m_run = 1'b0;
    exp_cycles = 0;
    tick();
    tick();
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_trap_addr", {16'd0, trap_addr}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    reset = 1'b1;
    hold_check();
  endtask

  // Wait (bounded) for done, pop the scoreboard entry and compare; then confirm freeze.
  task automatic check_result(input string tag);
    exp_t e;
    int   t;
    t = 0;
    while (!done && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
    chk({tag, "_trap_addr"}, {16'd0, trap_addr}, {16'd0, e.taddr});
    chk({tag, "_cycles"}, cycles, e.cyc);
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    sync = 1'b1;
    addr = 16'h1111;
    repeat (3) tick();
    sync = 1'b0;
    chk({tag, "_frozen_cycles"}, cycles, e.cyc);
    chk({tag, "_frozen_trap_addr"}, {16'd0, trap_addr}, {16'd0, e.taddr});
    chk({tag, "_still_done"}, {31'd0, done}, 32'd1);
    $display("%s: done=%0d pass=%0d trap_addr=%04h cycles=%0d", tag, done, pass, trap_addr, cycles);
  endtask

  initial begin
    vt[0] = '{n: 3, seq: '{16'h3469, 16'h3469, 16'h3469, 16'h0, 16'h0, 16'h0},
              trap_idx: 2, exp_pass: 1'b1, exp_taddr: 16'h3469};
    vt[1] = '{n: 6, seq: '{16'h0400, 16'h0400, 16'h0402, 16'h0400, 16'h0400, 16'h0400},
              trap_idx: 5, exp_pass: 1'b0, exp_taddr: 16'h0400};
    vt[2] = '{n: 4, seq: '{16'h1234, 16'h1235, 16'h1235, 16'h1235, 16'h0, 16'h0},
              trap_idx: 3, exp_pass: 1'b0, exp_taddr: 16'h1235};
    vt[3] = '{n: 5, seq: '{16'h3469, 16'h3468, 16'h3469, 16'h3469, 16'h3469, 16'h0},
              trap_idx: 4, exp_pass: 1'b1, exp_taddr: 16'h3469};
    vt[4] = '{n: 3, seq: '{16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0},
              trap_idx: 2, exp_pass: 1'b0, exp_taddr: 16'h0000};

    @(negedge clk);

    // Table-driven trap sequences.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int j = 0; j < vt[i].n; j++) begin
        addr = vt[i].seq[j];
        sync = 1'b1;
        if (j == vt[i].trap_idx)
          sb_q.push_back('{pass: vt[i].exp_pass, taddr: vt[i].exp_taddr, cyc: exp_cycles + 1});
        tick();
        sync = 1'b0;
        addr = 16'hFFFF;
        if (j == vt[i].trap_idx) m_run = 1'b0;
        chk($sformatf("vec%0d_fetch%0d_done", i, j), {31'd0, done},
            {31'd0, (j >= vt[i].trap_idx)});
        if (j == vt[i].trap_idx) break;
        tick();
      end
      check_result($sformatf("vec%0d", i));
    end

    // Reset in the middle of RUN restarts the full hold sequence.
    do_reset();
    repeat (50) tick();
    chk("midrun_cycles_50", cycles, exp_cycles);
    reset = 1'b0;
    m_run = 1'b0;
    tick();
    chk("midrun_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrun_rst_cycles", cycles, 32'd0);
    reset = 1'b1;
    hold_check();
    repeat (5) tick();
    chk("midrun_rerun_cycles", cycles, 32'd5);
    $display("midrun reset: cycles=%0d after re-hold", cycles);

`ifdef TEST_HARNESS_TIMEOUT_EN
    // No repeated fetch: forced fail exactly when cycles reaches the limit.
    do_reset();
    addr = 16'h0ABC;
    sb_q.push_back('{pass: 1'b0, taddr: 16'h0ABC, cyc: TMO});
    repeat (TMO - 1) tick();
    chk("timeout_not_yet", {31'd0, done}, 32'd0);
    tick();
    chk("timeout_now", {31'd0, done}, 32'd1);
    check_result("timeout");
`else
    // Without the timeout option the run continues past any limit.
    do_reset();
    repeat (TMO + 20) tick();
    chk("no_timeout_done", {31'd0, done}, 32'd0);
    chk("no_timeout_cycles", cycles, exp_cycles);
    $display("no timeout: done=%0d cycles=%0d", done, cycles);
`endif

    // Narrow counter saturates; single-repeat instance traps on the first fetch.
    reset2 = 1'b0;
    tick();
    tick();
    chk("sat_rst_cycles", {28'd0, cycles2}, 32'd0);
    chk("sat_rst_cpu_reset", {31'd0, cpu_reset2}, 32'd1);
    reset2 = 1'b1;
    chk("sat_hold0", {31'd0, cpu_reset2}, 32'd1);
    tick();
    chk("sat_hold1", {31'd0, cpu_reset2}, 32'd1);
    tick();
    chk("sat_run_cpu_reset", {31'd0, cpu_reset2}, 32'd0);
    chk("sat_run_cycles0", {28'd0, cycles2}, 32'd0);
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk($sformatf("sat_cycles_%0d", t), {28'd0, cycles2}, (t < 15) ? t : 15);
    end
    addr = 16'h3469;
    sync2 = 1'b1;
    tick();
    sync2 = 1'b0;
    chk("rep1_done", {31'd0, done2}, 32'd1);
    chk("rep1_pass", {31'd0, pass2}, 32'd1);
    chk("rep1_trap_addr", {16'd0, trap_addr2}, 32'h3469);
    chk("rep1_rdy", {31'd0, rdy2}, 32'd0);
    chk("rep1_cycles", {28'd0, cycles2}, 32'd15);
    $display("sat/rep1: cycles=%0d done=%0d pass=%0d", cycles2, done2, pass2);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
